// File: rtl/nlp_update_sched.sv
// nlp_update_sched
// Single-write-port scheduler for the next-line predictor table.
// IF3 may offer two updates per cycle (slot 0 then slot 1); they are buffered
// in an in-order circular queue. A backend resolution update always wins the
// write port; otherwise the queue head is drained, one entry per cycle.
// Optional feature macro: NLP_UPD_COALESCE_EN -- an IF3 update whose pc
// already sits in the queue rewrites that entry's tgt/bim/take in place
// instead of taking a new slot.
module nlp_update_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if3_v0,
    input  logic                     if3_v1,
    input  logic [31:0]              if3_pc0,
    input  logic [31:0]              if3_pc1,
    input  logic [31:0]              if3_tgt0,
    input  logic [31:0]              if3_tgt1,
    input  logic [1:0]               if3_bim0,
    input  logic [1:0]               if3_bim1,
    input  logic                     if3_take0,
    input  logic                     if3_take1,
    input  logic                     be_v,
    input  logic [31:0]              be_pc,
    input  logic [31:0]              be_tgt,
    input  logic [1:0]               be_bim,
    input  logic                     be_take,
    output logic                     wr_v,
    output logic [31:0]              wr_pc,
    output logic [31:0]              wr_tgt,
    output logic [1:0]               wr_bim,
    output logic                     wr_take,
    output logic [$clog2(DEPTH):0]   q_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

`ifdef NLP_UPD_COALESCE_EN
    localparam bit COALESCE_EN = 1'b1;
`else
    localparam bit COALESCE_EN = 1'b0;
`endif

    // Queue storage and pointers
    logic [31:0]    pc_q   [DEPTH];
    logic [31:0]    tgt_q  [DEPTH];
    logic [1:0]     bim_q  [DEPTH];
    logic           take_q [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    // Write port registers
    logic           wr_v_q, wr_v_d;
    logic [31:0]    wr_pc_q, wr_pc_d;
    logic [31:0]    wr_tgt_q, wr_tgt_d;
    logic [1:0]     wr_bim_q, wr_bim_d;
    logic           wr_take_q, wr_take_d;

    // Per-cycle decisions
    logic           pop_s;
    logic [CW-1:0]  free_s;
    logic [PW-1:0]  rel_s [DEPTH];
    logic [DEPTH-1:0] entry_live_s;
    logic           hit0_s, hit1_s;
    logic [PW-1:0]  hidx0_s, hidx1_s;
    logic           we0_s, we1_s;
    logic [PW-1:0]  widx0_s, widx1_s;
    logic           acc0_s, acc1_s;
    logic           drop0_s, drop1_s;
    logic [CNT_W:0] drop_sum_s;

    // Pop happens only when the backend leaves the port idle and no flush is pending
    always_comb begin
        pop_s  = (!flush) && (!be_v) && (count_q != {CW{1'b0}});
        free_s = CW'(DEPTH) - count_q;
    end

    // Mark queued entries eligible for coalescing (occupied and not being popped)
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rel_s[i]        = PW'(i) - head_q;
            entry_live_s[i] = ({1'b0, rel_s[i]} < count_q) &&
                              !(pop_s && (PW'(i) == head_q));
        end
    end

    // Search the live entries for a pc match on each incoming slot
    always_comb begin
        hit0_s  = 1'b0;
        hit1_s  = 1'b0;
        hidx0_s = {PW{1'b0}};
        hidx1_s = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (COALESCE_EN && entry_live_s[i] && (pc_q[i] == if3_pc0) && !hit0_s) begin
                hit0_s  = 1'b1;
                hidx0_s = PW'(i);
            end else begin
                hit0_s  = hit0_s;
            end
            if (COALESCE_EN && entry_live_s[i] && (pc_q[i] == if3_pc1) && !hit1_s) begin
                hit1_s  = 1'b1;
                hidx1_s = PW'(i);
            end else begin
                hit1_s  = hit1_s;
            end
        end
    end

    // Enqueue / coalesce / drop decision for slot 0 then slot 1
    always_comb begin
        we0_s   = 1'b0;
        we1_s   = 1'b0;
        widx0_s = tail_q;
        widx1_s = tail_q;
        acc0_s  = 1'b0;
        acc1_s  = 1'b0;
        drop0_s = 1'b0;
        drop1_s = 1'b0;
        if (!flush && if3_v0) begin
            if (hit0_s) begin
                we0_s   = 1'b1;
                widx0_s = hidx0_s;
            end else if (free_s != {CW{1'b0}}) begin
                we0_s   = 1'b1;
                widx0_s = tail_q;
                acc0_s  = 1'b1;
            end else begin
                drop0_s = 1'b1;
            end
        end else begin
            we0_s = 1'b0;
        end
        if (!flush && if3_v1) begin
            if (hit1_s) begin
                we1_s   = 1'b1;
                widx1_s = hidx1_s;
            end else if (COALESCE_EN && acc0_s && (if3_pc1 == if3_pc0)) begin
                // slot 1 folds into the entry slot 0 is creating this cycle
                we1_s   = 1'b1;
                widx1_s = tail_q;
            end else if (free_s > {{(CW-1){1'b0}}, acc0_s}) begin
                we1_s   = 1'b1;
                widx1_s = tail_q + PW'(acc0_s);
                acc1_s  = 1'b1;
            end else begin
                drop1_s = 1'b1;
            end
        end else begin
            we1_s = 1'b0;
        end
    end

    // Next pointers, occupancy and saturating drop counter
    always_comb begin
        drop_sum_s = {1'b0, drop_q} + (CNT_W+1)'(drop0_s) + (CNT_W+1)'(drop1_s);
        if (drop_sum_s[CNT_W]) begin
            drop_d = {CNT_W{1'b1}};
        end else begin
            drop_d = drop_sum_s[CNT_W-1:0];
        end
        if (flush) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            head_d  = head_q + PW'(pop_s);
            tail_d  = tail_q + PW'(acc0_s) + PW'(acc1_s);
            count_d = count_q + CW'(acc0_s) + CW'(acc1_s) - CW'(pop_s);
        end
    end

    // Write-port arbitration: backend first, then queue head, else hold fields
    always_comb begin
        wr_v_d    = 1'b0;
        wr_pc_d   = wr_pc_q;
        wr_tgt_d  = wr_tgt_q;
        wr_bim_d  = wr_bim_q;
        wr_take_d = wr_take_q;
        if (be_v) begin
            wr_v_d    = 1'b1;
            wr_pc_d   = be_pc;
            wr_tgt_d  = be_tgt;
            wr_bim_d  = be_bim;
            wr_take_d = be_take;
        end else if (pop_s) begin
            wr_v_d    = 1'b1;
            wr_pc_d   = pc_q[head_q];
            wr_tgt_d  = tgt_q[head_q];
            wr_bim_d  = bim_q[head_q];
            wr_take_d = take_q[head_q];
        end else begin
            wr_v_d    = 1'b0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= {PW{1'b0}};
            tail_q    <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            drop_q    <= {CNT_W{1'b0}};
            wr_v_q    <= 1'b0;
            wr_pc_q   <= 32'h0000_0000;
            wr_tgt_q  <= 32'h0000_0000;
            wr_bim_q  <= 2'b01;
            wr_take_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            wr_v_q    <= wr_v_d;
            wr_pc_q   <= wr_pc_d;
            wr_tgt_q  <= wr_tgt_d;
            wr_bim_q  <= wr_bim_d;
            wr_take_q <= wr_take_d;
        end
    end

    // Queue storage writes; slot 1 is applied after slot 0 so it wins on a shared entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= 32'h0000_0000;
                tgt_q[i]  <= 32'h0000_0000;
                bim_q[i]  <= 2'b01;
                take_q[i] <= 1'b0;
            end
        end else begin
            if (we0_s) begin
                pc_q[widx0_s]   <= if3_pc0;
                tgt_q[widx0_s]  <= if3_tgt0;
                bim_q[widx0_s]  <= if3_bim0;
                take_q[widx0_s] <= if3_take0;
            end
            if (we1_s) begin
                pc_q[widx1_s]   <= if3_pc1;
                tgt_q[widx1_s]  <= if3_tgt1;
                bim_q[widx1_s]  <= if3_bim1;
                take_q[widx1_s] <= if3_take1;
            end
        end
    end

    assign wr_v     = wr_v_q;
    assign wr_pc    = wr_pc_q;
    assign wr_tgt   = wr_tgt_q;
    assign wr_bim   = wr_bim_q;
    assign wr_take  = wr_take_q;
    assign q_cnt    = count_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_nlp_update_sched.sv
// Testbench for nlp_update_sched: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_nlp_update_sched;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int DMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if3_v0, if3_v1;
    logic [31:0] if3_pc0, if3_pc1, if3_tgt0, if3_tgt1;
    logic [1:0]  if3_bim0, if3_bim1;
    logic        if3_take0, if3_take1;
    logic        be_v;
    logic [31:0] be_pc, be_tgt;
    logic [1:0]  be_bim;
    logic        be_take;
    logic        wr_v;
    logic [31:0] wr_pc, wr_tgt;
    logic [1:0]  wr_bim;
    logic        wr_take;
    logic [2:0]  q_cnt;
    logic [CNT_W-1:0] drop_cnt;

    nlp_update_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if3_v0(if3_v0), .if3_v1(if3_v1),
        .if3_pc0(if3_pc0), .if3_pc1(if3_pc1),
        .if3_tgt0(if3_tgt0), .if3_tgt1(if3_tgt1),
        .if3_bim0(if3_bim0), .if3_bim1(if3_bim1),
        .if3_take0(if3_take0), .if3_take1(if3_take1),
        .be_v(be_v), .be_pc(be_pc), .be_tgt(be_tgt), .be_bim(be_bim), .be_take(be_take),
        .wr_v(wr_v), .wr_pc(wr_pc), .wr_tgt(wr_tgt), .wr_bim(wr_bim), .wr_take(wr_take),
        .q_cnt(q_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  bim;
        logic        take;
    } ent_t;

    // Reference model state
    ent_t mq[$];
    ent_t ew;
    logic ev;
    int   exp_drop;
    int   m_free;
    int   m_nacc;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ev       = 1'b0;
        ew.pc    = 32'h0;
        ew.tgt   = 32'h0;
        ew.bim   = 2'b01;
        ew.take  = 1'b0;
        exp_drop = 0;
    endtask

    // One IF3 slot: merge into a matching queued pc (if enabled), else take a free slot, else drop
    task automatic model_slot(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic [1:0] bim, input logic take);
        ent_t e;
        bit   done;
        done = 0;
        if (!v) return;
`ifdef NLP_UPD_COALESCE_EN
        foreach (mq[k]) begin
            if (!done && mq[k].pc == pc) begin
                mq[k].tgt  = tgt;
                mq[k].bim  = bim;
                mq[k].take = take;
                done = 1;
            end
        end
`endif
        if (!done) begin
            if (m_nacc < m_free) begin
                e.pc = pc; e.tgt = tgt; e.bim = bim; e.take = take;
                mq.push_back(e);
                m_nacc++;
            end else begin
                exp_drop = (exp_drop < DMAX) ? exp_drop + 1 : DMAX;
            end
        end
    endtask

    task automatic model_step();
        bit pop;
        pop = 0;
        if (be_v) begin
            ev = 1'b1;
            ew.pc = be_pc; ew.tgt = be_tgt; ew.bim = be_bim; ew.take = be_take;
        end else if (!flush && mq.size() > 0) begin
            ev = 1'b1;
            ew = mq[0];
            pop = 1;
        end else begin
            ev = 1'b0;
        end
        if (flush) begin
            mq.delete();
        end else begin
            m_free = DEPTH - mq.size();
            m_nacc = 0;
            if (pop) void'(mq.pop_front());
            model_slot(if3_v0, if3_pc0, if3_tgt0, if3_bim0, if3_take0);
            model_slot(if3_v1, if3_pc1, if3_tgt1, if3_bim1, if3_take1);
        end
    endtask

    task automatic compare_all();
        chk("wr_v",    64'(wr_v),     64'(ev));
        chk("wr_pc",   64'(wr_pc),    64'(ew.pc));
        chk("wr_tgt",  64'(wr_tgt),   64'(ew.tgt));
        chk("wr_bim",  64'(wr_bim),   64'(ew.bim));
        chk("wr_take", 64'(wr_take),  64'(ew.take));
        chk("q_cnt",   64'(q_cnt),    64'(mq.size()));
        chk("drop",    64'(drop_cnt), 64'(exp_drop));
    endtask

    // Clock one edge through model and DUT, check, return at the next falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle_in();
        flush = 1'b0; if3_v0 = 1'b0; if3_v1 = 1'b0; be_v = 1'b0;
    endtask

    task automatic set_s0(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] bim, input logic take);
        if3_v0 = 1'b1; if3_pc0 = pc; if3_tgt0 = tgt; if3_bim0 = bim; if3_take0 = take;
    endtask

    task automatic set_s1(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] bim, input logic take);
        if3_v1 = 1'b1; if3_pc1 = pc; if3_tgt1 = tgt; if3_bim1 = bim; if3_take1 = take;
    endtask

    task automatic set_be(input logic [31:0] pc, input logic [31:0] tgt);
        be_v = 1'b1; be_pc = pc; be_tgt = tgt; be_bim = pc[1:0]; be_take = pc[2];
    endtask

    logic [31:0] pool [6];

    initial begin
        pool[0] = 32'h40;  pool[1] = 32'h80;  pool[2] = 32'hC0;
        pool[3] = 32'h100; pool[4] = 32'h140; pool[5] = 32'h180;
        rst = 1'b1;
        idle_in();
        if3_pc0 = 32'h0; if3_pc1 = 32'h0; if3_tgt0 = 32'h0; if3_tgt1 = 32'h0;
        if3_bim0 = 2'b00; if3_bim1 = 2'b00; if3_take0 = 1'b0; if3_take1 = 1'b0;
        be_pc = 32'h0; be_tgt = 32'h0; be_bim = 2'b00; be_take = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_wr_v",  64'(wr_v),     64'd0);
        chk("rst_bim",   64'(wr_bim),   64'd1);
        chk("rst_pc",    64'(wr_pc),    64'd0);
        chk("rst_q_cnt", 64'(q_cnt),    64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        rst = 1'b0;

        // Single IF3 update: queued at N, written at N+2
        set_s0(32'h1000, 32'h2000, 2'd2, 1'b1);
        cyc();
        chk("lat_n1_wr_v",  64'(wr_v),  64'd0);
        chk("lat_n1_q_cnt", 64'(q_cnt), 64'd1);
        idle_in();
        cyc();
        chk("lat_n2_wr_v", 64'(wr_v),   64'd1);
        chk("lat_n2_pc",   64'(wr_pc),  64'h1000);
        chk("lat_n2_tgt",  64'(wr_tgt), 64'h2000);
        chk("lat_n2_bim",  64'(wr_bim), 64'd2);
        chk("lat_n2_q",    64'(q_cnt),  64'd0);
        cyc();

        // Backend holds the port for 6 cycles while IF3 pushes 2/cycle
        for (int k = 0; k < 6; k++) begin
            set_be(32'hB000 + 32'(k), 32'hBE00 + 32'(k));
            set_s0(32'h200 + 32'(2*k), 32'h300, 2'd1, 1'b0);
            set_s1(32'h201 + 32'(2*k), 32'h301, 2'd3, 1'b1);
            cyc();
            chk("be_wins_pc", 64'(wr_pc), 64'(32'hB000 + 32'(k)));
        end
        chk("be_q_full", 64'(q_cnt),    64'd4);
        chk("be_drop8",  64'(drop_cnt), 64'd8);

        // Flush with a full queue and same-cycle IF3 traffic
        idle_in();
        flush = 1'b1;
        set_s0(32'h900, 32'h901, 2'd0, 1'b0);
        set_s1(32'h902, 32'h903, 2'd0, 1'b0);
        cyc();
        chk("flush_q",    64'(q_cnt),    64'd0);
        chk("flush_wr_v", 64'(wr_v),     64'd0);
        chk("flush_drop", 64'(drop_cnt), 64'd8);
        idle_in();

        // Push 3 / drain 3, three times, to wrap the pointers
        for (int r = 0; r < 3; r++) begin
            set_s0(32'h500 + 32'(r*16), 32'h600 + 32'(r), 2'd0, 1'b1);
            set_s1(32'h504 + 32'(r*16), 32'h610 + 32'(r), 2'd1, 1'b0);
            cyc();
            idle_in();
            set_s0(32'h508 + 32'(r*16), 32'h620 + 32'(r), 2'd2, 1'b1);
            cyc();
            idle_in();
            repeat (3) cyc();
            chk("wrap_empty", 64'(q_cnt), 64'd0);
        end

        // Same pc enqueued twice while the backend blocks draining
        set_be(32'hA0, 32'hA1);
        set_s0(32'h40, 32'h80, 2'd1, 1'b0);
        cyc();
        set_s0(32'h40, 32'hC0, 2'd2, 1'b1);
        cyc();
`ifdef NLP_UPD_COALESCE_EN
        chk("coal_q", 64'(q_cnt), 64'd1);
`else
        chk("coal_q", 64'(q_cnt), 64'd2);
`endif
        idle_in();
        cyc();
        chk("coal_wr_pc", 64'(wr_pc), 64'h40);
`ifdef NLP_UPD_COALESCE_EN
        chk("coal_wr_tgt", 64'(wr_tgt), 64'hC0);
`else
        chk("coal_wr_tgt", 64'(wr_tgt), 64'h80);
`endif
        repeat (2) cyc();

        // Overflow traffic drives the drop counter into saturation
        for (int k = 0; k < 8; k++) begin
            set_be(32'hC000, 32'hC004);
            set_s0(32'h700 + 32'(k), 32'h1, 2'd0, 1'b0);
            set_s1(32'h780 + 32'(k), 32'h2, 2'd0, 1'b0);
            cyc();
        end
        chk("drop_sat", 64'(drop_cnt), 64'd15);

        // Reset in the middle of a drain
        idle_in();
        cyc();
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_v", 64'(wr_v),     64'd0);
        chk("mid_rst_q",    64'(q_cnt),    64'd0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic in phases of varying backend pressure
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 120; c++) begin
                idle_in();
                be_v = ($urandom_range(0, 9) < 2*ph % 10);
                be_pc = $urandom; be_tgt = $urandom;
                be_bim = 2'($urandom_range(0, 3)); be_take = 1'($urandom_range(0, 1));
                if3_v0 = 1'($urandom_range(0, 1));
                if3_v1 = 1'($urandom_range(0, 1));
                if3_pc0 = pool[$urandom_range(0, 5)];
                if3_pc1 = pool[$urandom_range(0, 5)];
                if3_tgt0 = $urandom; if3_tgt1 = $urandom;
                if3_bim0 = 2'($urandom_range(0, 3)); if3_bim1 = 2'($urandom_range(0, 3));
                if3_take0 = 1'($urandom_range(0, 1)); if3_take1 = 1'($urandom_range(0, 1));
                flush = ($urandom_range(0, 39) == 0);
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nlp_update_sched.md
# nlp_update_sched

Scheduler for the next-line predictor (NLP) table write port. Each cycle IF3 may produce two NLP updates (slot 0, slot 1) and the backend may produce one branch-resolution update, but the NLP table has a single write port. The block buffers IF3 updates in a small in-order queue, gives backend updates strict priority, and drains one update per cycle to the table. It sits between IF3 / backend commit and the NLP.

## Interface
Parameters:
- DEPTH, 4, IF3 update queue entries (power of two, ≥2)
- CNT_W, 16, width of drop counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  frontend flush; discards queued and same-cycle IF3 updates
- if3_v0 / if3_v1  in  1  IF3 slot-0 / slot-1 update valid
- if3_pc0 / if3_pc1  in  32  branch PC per slot
- if3_tgt0 / if3_tgt1  in  32  predicted target per slot
- if3_bim0 / if3_bim1  in  2  bimodal state per slot
- if3_take0 / if3_take1  in  1  shouldTake per slot
- be_v, be_pc[32], be_tgt[32], be_bim[2], be_take[1]  in  backend resolution update
- wr_v  out  1  NLP write enable (registered)
- wr_pc, wr_tgt, wr_bim, wr_take  out  32/32/2/1  NLP write fields (registered)
- q_cnt  out  $clog2(DEPTH)+1  current occupancy
- drop_cnt  out  CNT_W  saturating count of IF3 updates lost to a full queue

## Operation
- Queue: circular buffer, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus count register.
- Enqueue order within a cycle: slot 0 before slot 1. Free slots = DEPTH − count at the start of the cycle; a same-cycle pop does not free a slot for the current enqueue.
- If incoming valid updates exceed free slots, accept in slot order until full; each rejected update increments drop_cnt by 1, saturating at all-ones.
- Write-port arbitration each cycle:
  - be_v=1: register backend fields into wr_*, wr_v=1; queue does not pop.
  - else count>0: register head entry into wr_*, wr_v=1, pop head.
  - else wr_v=0; wr_* fields hold previous values.
- flush=1: count, head and tail reset to 0; same-cycle IF3 updates are ignored (not counted as drops); backend update still wins the write port; no pop is written.
- q_cnt reflects the registered count.

## Timing
- Reset values: wr_v=0, wr_pc=0, wr_tgt=0, wr_bim=2'b01, wr_take=0, q_cnt=0, drop_cnt=0, head=tail=0.
- Backend update: cycle N input → wr_v at N+1.
- IF3 update into an empty queue with no backend traffic: enqueue N, pop N+1, wr_v at N+2.
- Throughput: one write per cycle; the queue drains fully only when be_v=0.
- Simultaneous enqueue and pop: count_next = count + accepted − popped.
- Reset asserted mid-drain: all state cleared asynchronously; wr_v drops immediately.

## Configuration
- NLP_UPD_COALESCE_EN defined: an incoming IF3 update whose pc matches a valid queued entry, excluding the entry popped in the same cycle, overwrites that entry's tgt/bim/take in place and consumes no slot.
  - Coalesced updates never count as drops.
  - Slot 1 matching slot 0 in the same cycle coalesces into slot 0's new entry.
- Not defined: no pc compare; every valid update takes a slot or is dropped.

## Test plan
- Reset, then single if3_v0 (pc=0x1000, tgt=0x2000, bim=2, take=1) at cycle N → wr_v=1 with those fields at N+2; q_cnt returns to 0.
- be_v held high for 6 cycles while IF3 sends 2 updates/cycle → wr_* carries backend data every cycle; q_cnt reaches 4; drop_cnt=8 after 6 cycles.
- Queue full (4), flush=1 with if3_v0=if3_v1=1 → q_cnt=0 next cycle, wr_v=0, drop_cnt unchanged.
- Push 3, drain 3 with no backend, repeated 3 times → tail wraps past DEPTH−1; written pcs appear in exact enqueue order.
- drop_cnt preset near saturation via overflow traffic (CNT_W=4) → stops at 15, no wrap.
- With NLP_UPD_COALESCE_EN: queue holds pc=0x40 (tgt=0x80); new update pc=0x40 with tgt=0xC0 → q_cnt unchanged, later write has tgt=0xC0. Without the macro: q_cnt +1, two writes occur.
